sleep_timer_set: RTL and testbench

Front-panel setting stage for the sleep countdown. It debounces four push-buttons and lets the user edit a minutes/seconds preset. It arms and cancels the countdown and drives the preset and run-enable into the downstream countdown block. It watches that block's sleep_flag to latch completion and hold the panel until the user acknowledges.

---
 rtl/sleep_timer_set.sv | 197 +++++++++++++++++++
 tb/tb_sleep_timer_set.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sleep_timer_set.sv
// sleep_timer_set: front-panel setting stage for the sleep countdown.
// Debounces four push-buttons, edits a minutes:seconds preset, and arms,
// cancels and acknowledges the downstream countdown block.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn_mode          raw button, toggles the edited field
//   btn_up, btn_down  raw buttons, step the selected field (with auto-repeat)
//   btn_start         raw button, start / cancel / acknowledge
//   sleep_flag        countdown block reached 0:00
//   min_counter       minute preset (0..MAX_MIN)
//   sec_counter       second preset (0..59)
//   count_begin       run-enable to the countdown block
//   sel_field         0 = minutes edited, 1 = seconds edited
//   state             0 IDLE, 1 RUN, 2 DONE
//
// state | meaning
// IDLE  | presets editable, countdown held off
// RUN   | countdown enabled, presets frozen
// DONE  | countdown expired, held at 0:00 until start acknowledges
module sleep_timer_set #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100,
  parameter int unsigned MAX_MIN         = 99,
  parameter int unsigned DEFAULT_MIN     = 30,
  parameter int unsigned DEFAULT_SEC     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       sleep_flag,
  output logic [7:0] min_counter,
  output logic [7:0] sec_counter,
  output logic       count_begin,
  output logic       sel_field,
  output logic [1:0] state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Button index: 0 mode, 1 up, 2 down, 3 start
  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [3:0]      press_ev;

  // Auto-repeat timers: index 0 up, 1 down
  logic [RP_W-1:0] rpt_cnt_q [2];
  logic [1:0]      rpt_fire;

  logic mode_ev, up_ev, down_ev, start_ev;

  state_e     state_q, state_d;
  logic       cb_q, cb_d;
  logic       sel_q, sel_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;

  assign btn_raw = {btn_start, btn_down, btn_up, btn_mode};

  // Level flips only once DEBOUNCE_CYCLES consecutive synchronised samples
  // disagree with the current debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press_ev = deb_q & ~deb_prev_q;

  // Timer is loaded on the press event, so a zero count while the level
  // has been high for more than one cycle marks a repeat step.
  always_comb begin
    for (int j = 0; j < 2; j++)
      rpt_fire[j] = deb_q[j+1] & deb_prev_q[j+1] & (rpt_cnt_q[j] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) rpt_cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!deb_q[j+1])
          rpt_cnt_q[j] <= '0;
        else if (press_ev[j+1])
          rpt_cnt_q[j] <= RP_W'(REPEAT_DELAY - 1);
        else if (rpt_cnt_q[j] == '0)
          rpt_cnt_q[j] <= RP_W'(REPEAT_PERIOD - 1);
        else
          rpt_cnt_q[j] <= rpt_cnt_q[j] - RP_W'(1);
      end
    end
  end

  assign mode_ev  = press_ev[0];
  assign up_ev    = press_ev[1] | rpt_fire[0];
  assign down_ev  = press_ev[2] | rpt_fire[1];
  assign start_ev = press_ev[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cb_q    <= 1'b0;
      sel_q   <= 1'b0;
      min_q   <= 8'(DEFAULT_MIN);
      sec_q   <= 8'(DEFAULT_SEC);
    end else begin
      state_q <= state_d;
      cb_q    <= cb_d;
      sel_q   <= sel_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cb_d    = cb_q;
    sel_d   = sel_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: begin
        if (mode_ev) sel_d = ~sel_q;
        // Simultaneous up and down cancel each other.
        if (up_ev && !down_ev) begin
          if (!sel_q) min_d = (min_q == 8'(MAX_MIN)) ? 8'd0 : min_q + 8'd1;
          else        sec_d = (sec_q == 8'd59) ? 8'd0 : sec_q + 8'd1;
        end else if (down_ev && !up_ev) begin
          if (!sel_q) min_d = (min_q == 8'd0) ? 8'(MAX_MIN) : min_q - 8'd1;
          else        sec_d = (sec_q == 8'd0) ? 8'd59 : sec_q - 8'd1;
        end
        if (start_ev && (min_q != 8'd0 || sec_q != 8'd0)) begin
          state_d = RUN;
          cb_d    = 1'b1;
        end
      end
      RUN: begin
        // Cancel takes priority over a coincident expiry.
        if (start_ev) begin
          state_d = IDLE;
          cb_d    = 1'b0;
        end else if (sleep_flag) begin
          state_d = DONE;
          cb_d    = 1'b1;
        end
      end
      DONE: begin
        if (start_ev) begin
          state_d = IDLE;
          cb_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cb_d    = 1'b0;
      end
    endcase
  end

  assign min_counter = min_q;
  assign sec_counter = sec_q;
  assign count_begin = cb_q;
  assign sel_field   = sel_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sleep_timer_set.sv
module tb_sleep_timer_set;

  localparam int NV = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down, btn_start, sleep_flag;
  logic [7:0] min_counter, sec_counter;
  logic       count_begin, sel_field;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // act: 0 idle, 1 mode, 2 up, 3 down, 4 start, 5 sleep pulse, 6 up+down together
  typedef struct {
    int         act;
    logic [7:0] emin;
    logic [7:0] esec;
    logic       esel;
    logic [1:0] est;
    logic       ecb;
  } vec_t;

  vec_t tbl [NV];

  sleep_timer_set #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .MAX_MIN        (99),
    .DEFAULT_MIN    (30),
    .DEFAULT_SEC    (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_start  (btn_start),
    .sleep_flag (sleep_flag),
    .min_counter(min_counter),
    .sec_counter(sec_counter),
    .count_begin(count_begin),
    .sel_field  (sel_field),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int a, input int mn, input int sc,
                              input int sl, input int st, input int cb);
    vec_t v;
    v.act  = a;
    v.emin = 8'(mn);
    v.esec = 8'(sc);
    v.esel = 1'(sl);
    v.est  = 2'(st);
    v.ecb  = 1'(cb);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int mn, input int sc,
                       input int sl, input int st, input int cb);
    n_cmp++;
    if (min_counter !== 8'(mn) || sec_counter !== 8'(sc) || sel_field !== 1'(sl) ||
        state !== 2'(st) || count_begin !== 1'(cb)) begin
      n_err++;
      $display("FAIL %s: got min=%0d sec=%0d sel=%0d state=%0d cb=%0d, want min=%0d sec=%0d sel=%0d state=%0d cb=%0d",
               name, min_counter, sec_counter, sel_field, state, count_begin,
               mn, sc, sl, st, cb);
    end
  endtask

  // Hold 8 cycles: long enough to debounce, short of the repeat delay.
  task automatic press(input int a);
    case (a)
      1: btn_mode  = 1'b1;
      2: btn_up    = 1'b1;
      3: btn_down  = 1'b1;
      4: btn_start = 1'b1;
      6: begin btn_up = 1'b1; btn_down = 1'b1; end
      default: ;
    endcase
    repeat (8) tick();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_act(input int a);
    if (a == 0) begin
      repeat (4) tick();
    end else if (a == 5) begin
      sleep_flag = 1'b1;
      tick();
      sleep_flag = 1'b0;
      repeat (2) tick();
    end else begin
      press(a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic int exp_hold_min(input int k);
    if (k < 7)  return 30;
    if (k < 17) return 31;
    if (k < 20) return 32;
    if (k < 23) return 33;
    return 34;
  endfunction

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    btn_start = 1'b0; sleep_flag = 1'b0;

    tbl[0]  = mk(0, 30, 0, 0, 0, 0);
    tbl[1]  = mk(2, 31, 0, 0, 0, 0);
    tbl[2]  = mk(3, 30, 0, 0, 0, 0);
    tbl[3]  = mk(3, 29, 0, 0, 0, 0);
    tbl[4]  = mk(6, 29, 0, 0, 0, 0);
    tbl[5]  = mk(1, 29, 0, 1, 0, 0);
    tbl[6]  = mk(3, 29, 59, 1, 0, 0);
    tbl[7]  = mk(2, 29, 0, 1, 0, 0);
    tbl[8]  = mk(2, 29, 1, 1, 0, 0);
    tbl[9]  = mk(1, 29, 1, 0, 0, 0);
    tbl[10] = mk(4, 29, 1, 0, 1, 1);
    tbl[11] = mk(2, 29, 1, 0, 1, 1);
    tbl[12] = mk(1, 29, 1, 0, 1, 1);
    tbl[13] = mk(5, 29, 1, 0, 2, 1);
    tbl[14] = mk(3, 29, 1, 0, 2, 1);
    tbl[15] = mk(1, 29, 1, 0, 2, 1);
    tbl[16] = mk(4, 29, 1, 0, 0, 0);
    tbl[17] = mk(2, 30, 1, 0, 0, 0);
    tbl[18] = mk(4, 30, 1, 0, 1, 1);
    tbl[19] = mk(4, 30, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      do_act(tbl[i].act);
      check($sformatf("vec%0d", i), tbl[i].emin, tbl[i].esec, tbl[i].esel,
            tbl[i].est, tbl[i].ecb);
    end

    // Glitch shorter than the debounce window, then a long hold with repeat.
    do_reset();
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (10) tick();
    check("glitch", 30, 0, 0, 0, 0);
    btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 18) btn_up = 1'b0;
      check($sformatf("hold_k%0d", k), exp_hold_min(k), 0, 0, 0, 0);
    end

    // Minute wrap in both directions, second wrap, zero-preset start.
    do_reset();
    for (int i = 0; i < 30; i++) press(3);
    check("min_down_to_0", 0, 0, 0, 0, 0);
    press(3);
    check("min_wrap_down", 99, 0, 0, 0, 0);
    press(2);
    check("min_wrap_up", 0, 0, 0, 0, 0);
    press(1);
    press(3);
    check("sec_wrap_down", 0, 59, 1, 0, 0);
    press(2);
    check("sec_wrap_up", 0, 0, 1, 0, 0);
    press(4);
    check("start_at_zero", 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) press(2);
    check("sec_to_5", 0, 5, 1, 0, 0);
    press(4);
    check("start_run", 0, 5, 1, 1, 1);

    // Reset while running.
    rst = 1'b1;
    tick();
    check("rst_in_run", 30, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // Start event coincident with sleep_flag: cancel wins.
    press(4);
    check("run_again", 30, 0, 0, 1, 1);
    btn_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin
        check("pre_cancel", 30, 0, 0, 1, 1);
        sleep_flag = 1'b1;
      end
      if (k == 7) begin
        check("cancel_vs_sleep", 30, 0, 0, 0, 0);
        sleep_flag = 1'b0;
      end
    end
    btn_start = 1'b0;
    repeat (8) tick();
    check("after_cancel", 30, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
